// File: rtl/geofence_pkg.sv
// rtl/geofence_pkg.sv - shared constants, types and FSM states for the geofence feeder
package geofence_pkg;
  localparam int COORD_W       = 10;
  localparam int PTS_PER_FRAME = 7;
  localparam int FIFO_DEPTH    = 14;
  localparam int WAIT_TIMEOUT  = 255;
  localparam int PT_W          = 2 * COORD_W;
  localparam int PTR_W         = $clog2(FIFO_DEPTH);
  localparam int CNT_W         = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {HOLD, STREAM, WAIT} state_t;
endpackage

// File: rtl/geofence_if.sv
// rtl/geofence_if.sv - host point stream, engine link and result/status bundle
interface geofence_if;
  import geofence_pkg::*;

  logic               wr_valid;
  logic               wr_ready;
  logic [COORD_W-1:0] wr_x;
  logic [COORD_W-1:0] wr_y;
  logic               gf_reset;
  logic [COORD_W-1:0] gf_x;
  logic [COORD_W-1:0] gf_y;
  logic               gf_valid;
  logic               gf_is_inside;
  logic               res_valid;
  logic               res_inside;
  logic [7:0]         res_index;
  logic [7:0]         inside_cnt;
  logic               err_timeout;
  logic               err_protocol;

  // master: host/engine side; slave: the feeder
  modport master (
    output wr_valid, wr_x, wr_y, gf_valid, gf_is_inside,
    input  wr_ready, gf_reset, gf_x, gf_y, res_valid, res_inside, res_index,
           inside_cnt, err_timeout, err_protocol
  );
  modport slave (
    input  wr_valid, wr_x, wr_y, gf_valid, gf_is_inside,
    output wr_ready, gf_reset, gf_x, gf_y, res_valid, res_inside, res_index,
           inside_cnt, err_timeout, err_protocol
  );
endinterface

// File: rtl/geofence_feeder_point_fifo.sv
// rtl/geofence_feeder_point_fifo.sv - two-frame {x,y} point FIFO with modulo-14 pointers
module point_fifo
  import geofence_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [PT_W-1:0]  wdata,
  output logic [PT_W-1:0]  rdata,
  output logic [CNT_W-1:0] count,
  output logic             full
);
  logic [PT_W-1:0]  mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full    = (count == CNT_W'(FIFO_DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && (count != '0);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // storage needs no reset: only entries between the pointers are ever read
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end
endmodule

// File: rtl/geofence_feeder.sv
// rtl/geofence_feeder.sv - buffers 7-point frames and streams them to the geofence engine
module geofence_feeder
  import geofence_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  geofence_if.slave  bus
);
  state_t             state;
  state_t             next_state;
  logic [2:0]         idx;
  logic [7:0]         wait_cnt;
  logic               pop;
  logic               full;
  logic [CNT_W-1:0]   count;
  logic [PT_W-1:0]    head;
  logic               frame_avail;
  logic               result;
  logic               timeout;
  logic [COORD_W-1:0] gf_x_c;
  logic [COORD_W-1:0] gf_y_c;
  logic               gf_reset_q;
  logic               res_valid_q;
  logic               res_inside_q;
  logic [7:0]         res_index_q;
  logic [7:0]         inside_cnt_q;
  logic               err_timeout_q;
  logic               err_protocol_q;

  point_fifo u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (bus.wr_valid),
    .pop   (pop),
    .wdata ({bus.wr_x, bus.wr_y}),
    .rdata (head),
    .count (count),
    .full  (full)
  );

  assign frame_avail = (count >= CNT_W'(PTS_PER_FRAME));
  assign result      = (state == WAIT) && bus.gf_valid;
  assign timeout     = (state == WAIT) && !bus.gf_valid && (wait_cnt == 8'(WAIT_TIMEOUT - 1));

  always_comb begin
    next_state = state;
    pop        = 1'b0;
    gf_x_c     = '0;
    gf_y_c     = '0;
    case (state)
      HOLD: begin
        if (frame_avail) next_state = STREAM;
      end
      STREAM: begin
        pop    = 1'b1;
        gf_x_c = head[PT_W-1:COORD_W];
        gf_y_c = head[COORD_W-1:0];
        if (idx == 3'(PTS_PER_FRAME - 1)) next_state = WAIT;
      end
      WAIT: begin
        if (bus.gf_valid)  next_state = frame_avail ? STREAM : HOLD;
        else if (timeout)  next_state = HOLD;
      end
      default: next_state = HOLD;
    endcase
  end

  // gf_reset follows the next state so it drops on the very edge that enters STREAM
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= HOLD;
      idx        <= '0;
      wait_cnt   <= '0;
      gf_reset_q <= 1'b1;
    end else begin
      state      <= next_state;
      idx        <= (state == STREAM && next_state == STREAM) ? idx + 3'd1 : '0;
      wait_cnt   <= (state == WAIT && next_state == WAIT) ? wait_cnt + 8'd1 : '0;
      gf_reset_q <= (next_state == HOLD);
    end
  end

  // res_index names the frame being reported, so it advances once the pulse is over
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      res_valid_q    <= 1'b0;
      res_inside_q   <= 1'b0;
      res_index_q    <= '0;
      inside_cnt_q   <= '0;
      err_timeout_q  <= 1'b0;
      err_protocol_q <= 1'b0;
    end else begin
      res_valid_q <= result;
      if (result) res_inside_q <= bus.gf_is_inside;
      if (result && bus.gf_is_inside && inside_cnt_q != 8'hFF) inside_cnt_q <= inside_cnt_q + 8'd1;
      if (res_valid_q || timeout) res_index_q <= res_index_q + 8'd1;
      if (timeout) err_timeout_q <= 1'b1;
      if (bus.gf_valid && state != WAIT) err_protocol_q <= 1'b1;
    end
  end

  assign bus.wr_ready     = !full;
  assign bus.gf_reset     = gf_reset_q;
  assign bus.gf_x         = gf_x_c;
  assign bus.gf_y         = gf_y_c;
  assign bus.res_valid    = res_valid_q;
  assign bus.res_inside   = res_inside_q;
  assign bus.res_index    = res_index_q;
  assign bus.inside_cnt   = inside_cnt_q;
  assign bus.err_timeout  = err_timeout_q;
  assign bus.err_protocol = err_protocol_q;
endmodule

// File: tb/tb_geofence_feeder.sv
// tb/tb_geofence_feeder.sv - directed bench with engine model and per-cycle result scoreboard
module tb_geofence_feeder;
  import geofence_pkg::*;

  typedef logic [19:0] pts_t [7];

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  geofence_if bus ();
  geofence_feeder dut (.clk(clk), .reset(reset), .bus(bus));

  int total = 0;
  int bad   = 0;

  // test point then six vertices, as x,y pairs
  int frames [5][14] = '{
    '{ 5,  5,  0, 0, 10, 0, 10, 10,  5, 15,  0, 10,  0,  5},
    '{30, 30, 20,20, 40,20, 50, 35, 40, 50, 20, 50, 10, 35},
    '{60, 60,  0, 0, 10, 0, 10, 10,  5, 15,  0, 10,  0,  5},
    '{ 7, 12,  0, 0, 10, 0, 10, 10,  5, 15,  0, 10,  0,  5},
    '{ 1,  1, 20,20, 40,20, 50, 35, 40, 50, 20, 50, 10, 35}
  };

  logic [19:0] pushed [$];
  int   latency   = 2;
  bit   silent    = 0;
  bit   stray_req = 0;
  int   n_results = 0;

  int   n, lat, wcnt, exp_idx, exp_cnt;
  bit   exp_rv, exp_ri, exp_ep, exp_et, r;
  pts_t cap;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic bit pip(input pts_t p);
    int px, py, xi, yi, xj, yj, j;
    bit in;
    in = 0;
    px = int'(p[0][19:10]);
    py = int'(p[0][9:0]);
    for (int i = 1; i <= 6; i++) begin
      j  = (i == 6) ? 1 : i + 1;
      xi = int'(p[i][19:10]); yi = int'(p[i][9:0]);
      xj = int'(p[j][19:10]); yj = int'(p[j][9:0]);
      if ((yi > py) != (yj > py)) begin
        if (real'(px) < real'(xj - xi) * real'(py - yi) / real'(yj - yi) + real'(xi)) in = !in;
      end
    end
    return in;
  endfunction

  function automatic pts_t frame_pts(input int f);
    pts_t p;
    for (int i = 0; i < 7; i++) p[i] = {10'(frames[f][2*i]), 10'(frames[f][2*i+1])};
    return p;
  endfunction

  // engine model plus scoreboard, evaluated mid-cycle
  initial begin
    n = 0; lat = 0; wcnt = 0; exp_idx = 0; exp_cnt = 0;
    exp_rv = 0; exp_ri = 0; exp_ep = 0; exp_et = 0;
    bus.gf_valid = 1'b0; bus.gf_is_inside = 1'b0;
    forever begin
      @(negedge clk); #2;
      if (reset) begin
        n = 0; lat = 0; wcnt = 0; exp_idx = 0; exp_cnt = 0;
        exp_rv = 0; exp_ri = 0; exp_ep = 0; exp_et = 0;
        bus.gf_valid = 1'b0; stray_req = 0;
        check("reset_flags", int'({bus.gf_reset, bus.wr_ready, bus.res_valid, bus.res_inside,
                                   bus.err_timeout, bus.err_protocol}), 6'b110000);
        check("reset_gf_xy", int'({bus.gf_x, bus.gf_y}), 0);
        check("reset_counts", int'({bus.res_index, bus.inside_cnt}), 0);
        continue;
      end
      check("res_valid", int'(bus.res_valid), int'(exp_rv));
      if (exp_rv) check("res_inside", int'(bus.res_inside), int'(exp_ri));
      check("res_index", int'(bus.res_index), exp_idx);
      check("inside_cnt", int'(bus.inside_cnt), exp_cnt);
      check("err_timeout", int'(bus.err_timeout), int'(exp_et));
      check("err_protocol", int'(bus.err_protocol), int'(exp_ep));
      if (exp_rv) begin
        exp_idx = (exp_idx + 1) % 256;
        n_results++;
      end
      exp_rv = 0;
      bus.gf_valid = 1'b0;
      if (!bus.gf_reset && n < 7) begin
        if (pushed.size() == 0) begin
          check("stream_without_push", 1, 0);
        end else begin
          cap[n] = pushed.pop_front();
          check("stream_point", int'({bus.gf_x, bus.gf_y}), int'(cap[n]));
        end
        n++;
        if (n == 7) begin lat = 0; wcnt = 0; end
      end else begin
        check("idle_gf_xy", int'({bus.gf_x, bus.gf_y}), 0);
        if (n == 7) begin
          if (silent) begin
            wcnt++;
            if (wcnt == WAIT_TIMEOUT) begin
              exp_et = 1; exp_idx = (exp_idx + 1) % 256; n = 0;
            end
          end else if (lat >= latency) begin
            r = pip(cap);
            bus.gf_valid = 1'b1; bus.gf_is_inside = r;
            exp_rv = 1; exp_ri = r;
            if (r && exp_cnt < 255) exp_cnt++;
            n = 0;
          end else begin
            lat++;
          end
        end else if (stray_req) begin
          bus.gf_valid = 1'b1; bus.gf_is_inside = 1'b1;
          exp_ep = 1; stray_req = 0;
        end
      end
    end
  end

  task automatic push(input int x, input int y);
    int g;
    @(negedge clk);
    bus.wr_valid = 1'b1; bus.wr_x = 10'(x); bus.wr_y = 10'(y);
    #1;
    g = 0;
    while (!bus.wr_ready && g < 200) begin @(negedge clk); #1; g++; end
    if (!bus.wr_ready) check("push_accept", 0, 1);
    else pushed.push_back({10'(x), 10'(y)});
  endtask

  task automatic stop_push();
    @(negedge clk);
    bus.wr_valid = 1'b0;
  endtask

  task automatic push_frame(input int f);
    for (int i = 0; i < 7; i++) push(frames[f][2*i], frames[f][2*i+1]);
  endtask

  task automatic wait_results(input int target, input string name);
    int g = 0;
    while (n_results < target && g < 500) begin @(negedge clk); g++; end
    check(name, n_results, target);
  endtask

  task automatic wait_gf_reset(input logic v, input string name);
    int g = 0;
    while (bus.gf_reset !== v && g < 500) begin @(negedge clk); g++; end
    check(name, int'(bus.gf_reset), int'(v));
  endtask

  task automatic wait_res_valid(input string name);
    int g = 0;
    @(negedge clk);
    while (!bus.res_valid && g < 500) begin @(negedge clk); g++; end
    check(name, int'(bus.res_valid), 1);
  endtask

  initial begin
    bus.wr_valid = 1'b0; bus.wr_x = '0; bus.wr_y = '0;
    check("pip_inside_pin", int'(pip(frame_pts(0))), 1);
    check("pip_outside_pin", int'(pip(frame_pts(2))), 0);
    check("pip_hex2_pin", int'(pip(frame_pts(1))), 1);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst_wr_ready", int'(bus.wr_ready), 1);
    check("rst_gf_reset", int'(bus.gf_reset), 1);

    // single frame, inside result
    push_frame(0);
    stop_push();
    wait_res_valid("t1_res_seen");
    check("t1_res_inside", int'(bus.res_inside), 1);
    check("t1_res_index_during", int'(bus.res_index), 0);
    @(negedge clk);
    check("t1_res_index_after", int'(bus.res_index), 1);
    check("t1_inside_cnt", int'(bus.inside_cnt), 1);
    wait_gf_reset(1'b1, "t1_back_to_hold");

    // fill FIFO while engine is slow, then back-to-back frames
    latency = 40;
    push_frame(1); push_frame(2); push_frame(3);
    stop_push();
    #1 check("t2_full_wr_ready", int'(bus.wr_ready), 0);
    latency = 2;
    wait_res_valid("t2_res_seen");
    check("t2_b2b_gf_reset", int'(bus.gf_reset), 0);
    wait_results(4, "t2_results");
    wait_gf_reset(1'b1, "t2_back_to_hold");

    // partial frame must wait in HOLD
    for (int i = 0; i < 6; i++) push(frames[4][2*i], frames[4][2*i+1]);
    stop_push();
    repeat (5) begin
      @(negedge clk);
      check("t3_hold_partial", int'(bus.gf_reset), 1);
    end
    push(frames[4][12], frames[4][13]);
    stop_push();
    @(negedge clk);
    check("t3_stream_started", int'(bus.gf_reset), 0);
    wait_results(5, "t3_results");
    wait_gf_reset(1'b1, "t3_back_to_hold");

    // engine never answers
    silent = 1;
    push_frame(1);
    stop_push();
    begin
      int g = 0;
      while (!bus.err_timeout && g < 400) begin @(negedge clk); g++; end
    end
    check("t4_err_timeout", int'(bus.err_timeout), 1);
    @(negedge clk);
    check("t4_hold", int'(bus.gf_reset), 1);
    check("t4_no_result", n_results, 5);
    silent = 0;

    // stray gf_valid in HOLD
    stray_req = 1;
    repeat (3) @(negedge clk);
    check("t5_err_protocol", int'(bus.err_protocol), 1);
    check("t5_no_result", n_results, 5);

    // reset in the middle of STREAM
    push_frame(0);
    stop_push();
    wait_gf_reset(1'b0, "t6_stream_seen");
    repeat (3) @(negedge clk);
    #4 reset = 1'b1;
    pushed.delete();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    check("t6_wr_ready", int'(bus.wr_ready), 1);
    check("t6_gf_reset", int'(bus.gf_reset), 1);
    check("t6_err_flags", int'({bus.err_timeout, bus.err_protocol}), 0);
    push_frame(1);
    stop_push();
    wait_results(6, "t6_results");
    @(negedge clk);
    check("t6_res_index", int'(bus.res_index), 1);
    check("t6_inside_cnt", int'(bus.inside_cnt), 1);

    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
